// File: rtl/genius_tone_sequencer.sv
// Genius tone sequencer: plays the stored colour sequence on the buzzer
// and otherwise passes the player's button press straight through.
module genius_tone_sequencer #(
  parameter int NOTE_TICKS = 20000000,
  parameter int GAP_TICKS  = 5000000,
  parameter int CNT_W      = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [4:0] seq_len,
  output logic [3:0] rd_addr,
  input  logic [2:0] rd_note,
  input  logic       press_valid,
  input  logic [2:0] press_note,
  output logic [2:0] thing,
  output logic       SE,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NOTE = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] NOTE_LAST = CNT_W'(NOTE_TICKS - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_TICKS - 1);

  state_t           state_q;
  logic [4:0]       idx_q;
  logic [4:0]       len_q;
  logic [4:0]       len_d;
  logic [CNT_W-1:0] tick_q;
  logic [2:0]       thing_q;
  logic             se_q;
  logic             done_q;

  // A full 16-note game is the longest sequence the store can hold.
  assign len_d = (seq_len > 5'd16) ? 5'd16 : seq_len;

  assign rd_addr = idx_q[3:0];
  assign thing   = thing_q;
  assign SE      = se_q;
  assign busy    = (state_q != IDLE);
  assign done    = done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      tick_q  <= '0;
      thing_q <= '0;
      se_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          idx_q <= '0;
          if (start && (seq_len != 5'd0)) begin
            len_q   <= len_d;
            thing_q <= rd_note;
            se_q    <= 1'b1;
            tick_q  <= '0;
            state_q <= NOTE;
          end else begin
            done_q <= start;
            se_q   <= press_valid;
            if (press_valid) begin
              thing_q <= press_note;
            end
          end
        end
        NOTE: begin
          if (abort) begin
            state_q <= IDLE;
            se_q    <= 1'b0;
            idx_q   <= '0;
            tick_q  <= '0;
          end else if (tick_q == NOTE_LAST) begin
            se_q    <= 1'b0;
            tick_q  <= '0;
            idx_q   <= idx_q + 5'd1;
            state_q <= GAP;
          end else begin
            tick_q <= tick_q + 1'b1;
          end
        end
        GAP: begin
          if (abort) begin
            state_q <= IDLE;
            se_q    <= 1'b0;
            idx_q   <= '0;
            tick_q  <= '0;
          end else if (tick_q == GAP_LAST) begin
            tick_q <= '0;
            if (idx_q == len_q) begin
              // idx back to 0 so the next start reads the first note
              state_q <= IDLE;
              done_q  <= 1'b1;
              idx_q   <= '0;
            end else begin
              thing_q <= rd_note;
              se_q    <= 1'b1;
              state_q <= NOTE;
            end
          end else begin
            tick_q <= tick_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          se_q    <= 1'b0;
          idx_q   <= '0;
          tick_q  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_genius_tone_sequencer.sv
// Bench for genius_tone_sequencer with NOTE_TICKS=4, GAP_TICKS=2:
// table vectors for idle behaviour plus timeline-based playback runs.
module tb_genius_tone_sequencer;

  localparam int NT = 4;
  localparam int GT = 2;
  localparam int P  = NT + GT;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       abort;
  logic [4:0] seq_len;
  logic [3:0] rd_addr;
  logic [2:0] rd_note;
  logic       press_valid;
  logic [2:0] press_note;
  logic [2:0] thing;
  logic       SE;
  logic       busy;
  logic       done;

  logic [2:0] mem [16];
  assign rd_note = mem[rd_addr];

  always #5 clk = ~clk;

  genius_tone_sequencer #(
    .NOTE_TICKS(NT),
    .GAP_TICKS (GT),
    .CNT_W     (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .seq_len    (seq_len),
    .rd_addr    (rd_addr),
    .rd_note    (rd_note),
    .press_valid(press_valid),
    .press_note (press_note),
    .thing      (thing),
    .SE         (SE),
    .busy       (busy),
    .done       (done)
  );

  typedef struct packed {
    logic [2:0] thing;
    logic       se;
    logic       busy;
    logic       done;
    logic [3:0] addr;
  } exp_t;

  typedef struct {
    logic       rst;
    logic       start;
    logic [4:0] len;
    logic       abort;
    logic       pv;
    logic [2:0] pn;
    exp_t       e;
  } vec_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic exp_t mk(input logic [2:0] t, input logic s,
                              input logic b, input logic d,
                              input logic [3:0] a);
    exp_t e;
    e.thing = t;
    e.se    = s;
    e.busy  = b;
    e.done  = d;
    e.addr  = a;
    return e;
  endfunction

  // Expected outputs k cycles after the start edge of an n-note playback.
  function automatic exp_t play(input int k, input int n);
    int i;
    int pos;
    if (k <= n * P) begin
      i   = (k - 1) / P;
      pos = (k - 1) % P;
      if (pos < NT) return mk(mem[i], 1'b1, 1'b1, 1'b0, 4'(i));
      return mk(mem[i], 1'b0, 1'b1, 1'b0, 4'(i + 1));
    end
    return mk(mem[n-1], 1'b0, 1'b0, (k == n * P + 1), 4'd0);
  endfunction

  task automatic drive(input string nm, input logic r, input logic s,
                       input logic [4:0] l, input logic a,
                       input logic pv, input logic [2:0] pn,
                       input exp_t e);
    exp_t x;
    rst         = r;
    start       = s;
    seq_len     = l;
    abort       = a;
    press_valid = pv;
    press_note  = pn;
    sb.push_back(e);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    checks++;
    if ({thing, SE, busy, done, rd_addr} !== x) begin
      failures++;
      $display("FAIL %s t=%0t got thing=%0d SE=%0b busy=%0b done=%0b addr=%0d exp thing=%0d SE=%0b busy=%0b done=%0b addr=%0d",
               nm, $time, thing, SE, busy, done, rd_addr,
               x.thing, x.se, x.busy, x.done, x.addr);
    end
  endtask

  // noisy: hold start and press with random values while busy
  task automatic play_run(input string nm, input int n,
                          input logic [4:0] sl, input bit noisy,
                          input logic pv0, input logic [2:0] pn0);
    drive(nm, 1'b0, 1'b1, sl, 1'b0, pv0, pn0, play(1, n));
    for (int k = 2; k <= n * P + 1; k++) begin
      if (noisy)
        drive(nm, 1'b0, 1'b1, 5'($urandom_range(1, 31)), 1'b0, 1'b1,
              3'($urandom_range(0, 7)), play(k, n));
      else
        drive(nm, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 3'd0, play(k, n));
    end
    drive({nm, "_after"}, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 3'd0,
          play(n * P + 2, n));
  endtask

  vec_t tbl[$];

  initial begin
    mem = '{3'd3, 3'd5, 3'd1, 3'd7, 3'd2, 3'd6, 3'd4, 3'd0,
            3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd3};
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    seq_len = 5'd0;
    press_valid = 1'b0;
    press_note = 3'd0;

    // reset held with start and press asserted, then release quietly
    tbl.push_back('{1, 1, 5'd5, 0, 1, 3'd6, mk(3'd0, 0, 0, 0, 4'd0)});
    tbl.push_back('{1, 1, 5'd5, 0, 1, 3'd6, mk(3'd0, 0, 0, 0, 4'd0)});
    tbl.push_back('{0, 0, 5'd0, 0, 0, 3'd0, mk(3'd0, 0, 0, 0, 4'd0)});
    tbl.push_back('{0, 0, 5'd0, 0, 0, 3'd0, mk(3'd0, 0, 0, 0, 4'd0)});
    // press pass-through in idle
    tbl.push_back('{0, 0, 5'd0, 0, 1, 3'd6, mk(3'd6, 1, 0, 0, 4'd0)});
    tbl.push_back('{0, 0, 5'd0, 0, 0, 3'd2, mk(3'd6, 0, 0, 0, 4'd0)});
    tbl.push_back('{0, 0, 5'd0, 1, 1, 3'd1, mk(3'd1, 1, 0, 0, 4'd0)});
    tbl.push_back('{0, 0, 5'd0, 0, 1, 3'd7, mk(3'd7, 1, 0, 0, 4'd0)});
    // zero-length start: single done, never busy
    tbl.push_back('{0, 1, 5'd0, 0, 0, 3'd3, mk(3'd7, 0, 0, 1, 4'd0)});
    tbl.push_back('{0, 0, 5'd0, 0, 0, 3'd0, mk(3'd7, 0, 0, 0, 4'd0)});
    tbl.push_back('{0, 1, 5'd0, 0, 1, 3'd5, mk(3'd5, 1, 0, 1, 4'd0)});
    tbl.push_back('{0, 0, 5'd0, 0, 1, 3'd6, mk(3'd6, 1, 0, 0, 4'd0)});

    for (int i = 0; i < tbl.size(); i++)
      drive($sformatf("vec%0d", i), tbl[i].rst, tbl[i].start, tbl[i].len,
            tbl[i].abort, tbl[i].pv, tbl[i].pn, tbl[i].e);

    // start during a held press: playback wins, presses ignored while busy
    play_run("press_start", 3, 5'd3, 1'b1, 1'b1, 3'd6);
    play_run("three_note", 3, 5'd3, 1'b0, 1'b0, 3'd0);

    // abort inside the second note
    drive("abort_pre", 1'b0, 1'b1, 5'd3, 1'b0, 1'b0, 3'd0, play(1, 3));
    for (int k = 2; k <= 8; k++)
      drive("abort_pre", 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 3'd0, play(k, 3));
    drive("abort", 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 3'd0,
          mk(3'd5, 0, 0, 0, 4'd0));
    for (int k = 0; k < 3; k++)
      drive("abort_idle", 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 3'd0,
            mk(3'd5, 0, 0, 0, 4'd0));
    play_run("post_abort", 2, 5'd2, 1'b0, 1'b0, 3'd0);

    play_run("len16", 16, 5'd16, 1'b1, 1'b0, 3'd0);
    play_run("clamp31", 16, 5'd31, 1'b0, 1'b0, 3'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
